// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fabric_cfg_pkg
// Brief    : Shared types, default geometry and width helpers for the loader.
// Revision : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STROBE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } loader_state_e;

    // Geometry of the default fabric build.
    localparam int FRAME_WIDTH  = 32 * 10;
    localparam int STROBE_WIDTH = 20 * 6;
    localparam int TOTAL_FRAMES = STROBE_WIDTH;

    // Bits needed to index 0..n-1 (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a count 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fabric_cfg_strobe_timer.sv
`default_nettype none
// ============================================================================
// Module   : fabric_cfg_strobe_timer
// Brief    : Loadable down-counter timing the strobe-high and gap phases.
// Revision : 1.0 - initial release
// ============================================================================
module fabric_cfg_strobe_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Loaded with duration-1, so a phase ends in the cycle the count reads zero.
    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fabric_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : fabric_cfg_loader
// Brief    : Streams config words into frames and strobes them into the fabric.
// Revision : 1.0 - initial release
// ============================================================================
module fabric_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int NUM_COLUMNS        = 6,
    parameter int NUM_ROWS           = 10,
    parameter int STROBE_CYCLES      = 1,
    parameter int GAP_CYCLES         = 1
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           start_i,
    input  logic                                           abort_i,
    input  logic [FRAME_BITS_PER_ROW-1:0]                  word_i,
    input  logic                                           word_valid_i,
    output logic                                           word_ready_o,
    output logic [FRAME_BITS_PER_ROW*NUM_ROWS-1:0]         FrameData_o,
    output logic [MAX_FRAMES_PER_COL*NUM_COLUMNS-1:0]      FrameStrobe_o,
    output logic                                           busy_o,
    output logic                                           configured_o,
    output logic [$clog2(MAX_FRAMES_PER_COL*NUM_COLUMNS+1)-1:0] frames_done_o
);

    localparam int c_FRAME_W  = FRAME_BITS_PER_ROW * NUM_ROWS;
    localparam int c_STROBE_W = MAX_FRAMES_PER_COL * NUM_COLUMNS;
    localparam int c_ROW_W    = idx_width(NUM_ROWS);
    localparam int c_DONE_W   = cnt_width(c_STROBE_W);
    localparam int c_TMR_W    = idx_width((STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES);

    localparam logic [c_ROW_W-1:0]    c_LAST_ROW   = c_ROW_W'(NUM_ROWS - 1);
    localparam logic [c_DONE_W-1:0]   c_TOTAL      = c_DONE_W'(c_STROBE_W);
    localparam logic [c_STROBE_W-1:0] c_STROBE_ONE = c_STROBE_W'(1);
    localparam logic [c_TMR_W-1:0]    c_STROBE_LEN = c_TMR_W'(STROBE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]    c_GAP_LEN    = c_TMR_W'(GAP_CYCLES - 1);

    loader_state_e           r_state;
    loader_state_e           w_next;
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_configured;
    logic [c_STROBE_W-1:0]   r_strobe;
    logic [c_FRAME_W-1:0]    r_frame_data;
    logic [c_ROW_W-1:0]      r_row;
    logic [c_DONE_W-1:0]     r_frames_done;
    logic                    w_hs;
    logic                    w_start;
    logic                    w_write;
    logic                    w_tmr_load;
    logic [c_TMR_W-1:0]      w_tmr_val;
    logic                    w_tmr_done;

    assign w_hs    = r_ready & word_valid_i;
    assign w_start = ((r_state == IDLE) || (r_state == DONE)) & start_i;
    assign w_write = w_hs & ~abort_i;

    fabric_cfg_strobe_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) w_next = LOAD;
            end
            LOAD: begin
                if (abort_i) begin
                    w_next = IDLE;
                end else if (w_hs && (r_row == c_LAST_ROW)) begin
                    w_next     = STROBE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_STROBE_LEN;
                end
            end
            STROBE: begin
                if (abort_i) begin
                    w_next = IDLE;
                end else if (w_tmr_done) begin
                    w_next     = GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_GAP_LEN;
                end
            end
            GAP: begin
                if (abort_i) w_next = IDLE;
                else if (w_tmr_done) w_next = (r_frames_done == c_TOTAL) ? DONE : LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_ready       <= 1'b0;
            r_busy        <= 1'b0;
            r_configured  <= 1'b0;
            r_strobe      <= '0;
            r_frame_data  <= '0;
            r_row         <= '0;
            r_frames_done <= '0;
        end else begin
            r_state      <= w_next;
            r_ready      <= (w_next == LOAD);
            r_busy       <= (w_next == LOAD) || (w_next == STROBE) || (w_next == GAP);
            r_configured <= (w_next == DONE);
            // Frames go out column-major, so col*MAX_FRAMES_PER_COL+frame equals frames already done.
            r_strobe     <= (w_next == STROBE) ? (c_STROBE_ONE << r_frames_done) : '0;

            if (w_start) begin
                r_row         <= '0;
                r_frames_done <= '0;
            end
            if (w_write) begin
                for (int i = 0; i < NUM_ROWS; i++) begin
                    if (r_row == c_ROW_W'(i)) r_frame_data[i*FRAME_BITS_PER_ROW +: FRAME_BITS_PER_ROW] <= word_i;
                end
                r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + c_ROW_W'(1);
            end
            if ((r_state == STROBE) && (w_next == GAP)) r_frames_done <= r_frames_done + c_DONE_W'(1);
            // An abort drops any partial frame so the next pass starts at row 0.
            if (w_next == IDLE) r_row <= '0;
        end
    end

    assign word_ready_o  = r_ready;
    assign FrameData_o   = r_frame_data;
    assign FrameStrobe_o = r_strobe;
    assign busy_o        = r_busy;
    assign configured_o  = r_configured;
    assign frames_done_o = r_frames_done;

endmodule
`default_nettype wire

// File: doc/fabric_cfg_loader.md
Name: fabric_cfg_loader

Overview:
- Parametrised configuration front-end for the eFPGA fabric. Replaces direct host driving of the FrameData/FrameStrobe buses.
- Accepts a stream of configuration words over a valid/ready handshake and assembles them into full frames of FrameBitsPerRow*NumRows bits.
- Fires the matching FrameStrobe bit per frame with programmable pulse width and setup gap, then raises configured_o once every column/frame has been written.
- Sits between the SoC config interface and fabric_wrapper; configured_o drives its configured_i.

Parameters:
- FrameBitsPerRow, 32, word width and bits per row slice of FrameData.
- MaxFramesPerCol, 20, frames per column (strobe bits per column).
- NumColumns, 6, fabric columns.
- NumRows, 10, fabric rows (words per frame).
- STROBE_CYCLES, 1, strobe high duration in cycles, ≥1.
- GAP_CYCLES, 1, strobe-low cycles after each strobe before the next word is accepted, ≥1.

Ports:
- clk_i  in  1  fabric/user clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  begin a full configuration pass.
- abort_i  in  1  cancel an in-progress pass.
- word_i  in  FrameBitsPerRow  configuration word.
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  loader accepts word_i this cycle.
- FrameData_o  out  FrameBitsPerRow*NumRows  to fabric FrameData.
- FrameStrobe_o  out  MaxFramesPerCol*NumColumns  to fabric FrameStrobe, at most one bit high.
- busy_o  out  1  pass in progress.
- configured_o  out  1  full pass completed.
- frames_done_o  out  $clog2(MaxFramesPerCol*NumColumns+1)  frames strobed in the current pass.

Behaviour:
- Outputs registered. All state changes occur on the rising edge of clk_i.
- Reset, synchronous active-high (rst_i): state IDLE; FrameData_o=0; FrameStrobe_o=0; word_ready_o=0; busy_o=0; configured_o=0; frames_done_o=0; all counters 0. Reset wins over every other input.
- States:
  - IDLE, LOAD, STROBE, GAP, DONE.
  - busy_o=1 in LOAD, STROBE and GAP.
  - word_ready_o=1 only in LOAD.
- IDLE or DONE with start_i=1: next cycle LOAD; counters row/frame/col cleared; configured_o=0; frames_done_o=0. FrameData_o retains its old value.
- start_i while busy: ignored.
- LOAD:
  - On each handshake (word_valid_i & word_ready_o), word_i is written to FrameData_o[row*FrameBitsPerRow +: FrameBitsPerRow] and row increments.
  - On the handshake with row==NumRows-1: row wraps to 0 and the next state is STROBE.
  - No words are accepted in the cycle the FSM leaves LOAD.
- STROBE:
  - FrameStrobe_o bit (col*MaxFramesPerCol+frame) is high for exactly STROBE_CYCLES cycles; FrameData_o is stable throughout.
  - Then GAP.
- GAP:
  - FrameStrobe_o=0 and FrameData_o stable for GAP_CYCLES cycles.
  - frames_done_o increments on entry to GAP.
  - frame increments; it wraps at MaxFramesPerCol and col then increments.
  - On exit: if the last frame of the last column was written, go to DONE; otherwise go to LOAD.
- DONE: configured_o=1, held until start_i or reset.
- abort_i in LOAD, STROBE or GAP:
  - Next cycle IDLE; FrameStrobe_o=0; configured_o stays 0; frames_done_o holds its value.
  - A partial frame is discarded.
- abort_i in IDLE or DONE: ignored.
- Simultaneous abort_i and a handshake: abort wins; the word is not written.
- Simultaneous start_i and abort_i in IDLE/DONE: start wins.
- Word-to-strobe latency: the last word of a frame is accepted in cycle t; the strobe is high in cycles t+1..t+STROBE_CYCLES.
- Handshake stalls: word_valid_i low in LOAD stalls with no timeout; any inter-word gap is legal.
- Full pass length: exactly NumColumns*MaxFramesPerCol*NumRows accepted words.

Decomposition:
- Package fabric_cfg_pkg:
  - loader_state_e enum (IDLE, LOAD, STROBE, GAP, DONE).
  - localparams FRAME_WIDTH = FrameBitsPerRow*NumRows, STROBE_WIDTH = MaxFramesPerCol*NumColumns, TOTAL_FRAMES.
  - Counter width functions.
- One sub-module: fabric_cfg_strobe_timer, a down-counter producing the STROBE/GAP durations, reused for both phases.

Test Plan:
- Reset mid-pass: assert rst_i while in STROBE → next cycle all outputs 0, state IDLE, FrameStrobe_o=0.
- Single frame, defaults: start_i, then 10 words 0x00000001..0x0000000A with valid held high → FrameData_o[31:0]=1 and [319:288]=0xA; FrameStrobe_o[0] high for 1 cycle, one cycle after the 10th handshake; frames_done_o=1.
- Full pass with random valid gaps (120 frames, 1200 words) → strobe bits 0..119 each pulsed once, in order; configured_o=1 after the final GAP; word_ready_o=0 in DONE.
- Column wrap: after frame 19 of col 0, the next frame → FrameStrobe_o[20] pulses; frames_done_o 20→21.
- Timing with STROBE_CYCLES=3, GAP_CYCLES=2 → strobe high 3 cycles, then low 2 cycles before word_ready_o rises; FrameData_o unchanged across all 5 cycles.
- Abort after 5 words of frame 3 → IDLE next cycle; frames_done_o=3; configured_o=0; a new start_i restarts at strobe bit 0.
